// File: rtl/mem_streamer_if.sv
// mem_streamer_if: start/stream/memory-read bundle for mem_streamer; master is the streamer side.
// out_last exists only when MEM_STREAMER_LAST_EN is defined.
interface mem_streamer_if #(
  parameter int DEPTH    = 8,
  parameter int BIT_SIZE = 16
);
  logic                start;
  logic [DEPTH-1:0]    base_addr;
  logic [DEPTH:0]      length;
  logic [DEPTH-1:0]    read_addr;
  logic [BIT_SIZE-1:0] mem_data;
  logic [BIT_SIZE-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;
`ifdef MEM_STREAMER_LAST_EN
  logic                out_last;
`endif
  modport master (
`ifdef MEM_STREAMER_LAST_EN
    output out_last,
`endif
    input  start, base_addr, length, mem_data, out_ready,
    output read_addr, out_data, out_valid, busy, done
  );
  modport slave (
`ifdef MEM_STREAMER_LAST_EN
    input  out_last,
`endif
    output start, base_addr, length, mem_data, out_ready,
    input  read_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/mem_streamer.sv
// mem_streamer: streams length words from an async-read memory starting at base_addr over a valid/ready port.
// Define MEM_STREAMER_LAST_EN to add the registered out_last marker on the final word.
module mem_streamer #(
  parameter int DEPTH    = 8,
  parameter int BIT_SIZE = 16
) (
  input logic            clk,
  input logic            rst_n,
  mem_streamer_if.master bus
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t              state_q, state_d;
  logic [DEPTH-1:0]    addr_q, addr_d;
  logic [DEPTH:0]      rem_q, rem_d;
  logic [BIT_SIZE-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                cap;
  logic                final_word;
`ifdef MEM_STREAMER_LAST_EN
  logic                last_q, last_d;
`endif
  assign cap        = (state_q == STREAM) && (!valid_q || bus.out_ready);
  assign final_word = rem_q == (DEPTH+1)'(1);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef MEM_STREAMER_LAST_EN
    last_d  = last_q;
`endif
    if (state_q == IDLE && bus.start) begin
      done_d  = bus.length == '0;
      addr_d  = bus.length == '0 ? addr_q : bus.base_addr;
      rem_d   = bus.length == '0 ? rem_q : bus.length;
      state_d = bus.length == '0 ? IDLE : STREAM;
    end
    // a capture both refills the output register and advances the read pointer
    if (cap) begin
      data_d  = bus.mem_data;
      valid_d = 1'b1;
      addr_d  = addr_q + 1'b1;
      rem_d   = rem_q - 1'b1;
      state_d = final_word ? DRAIN : STREAM;
`ifdef MEM_STREAMER_LAST_EN
      last_d  = final_word;
`endif
    end
    if (state_q == DRAIN && bus.out_ready) begin
      valid_d = 1'b0;
      done_d  = 1'b1;
      state_d = IDLE;
`ifdef MEM_STREAMER_LAST_EN
      last_d  = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_STREAMER_LAST_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef MEM_STREAMER_LAST_EN
      last_q  <= last_d;
`endif
    end
  end
  assign bus.read_addr = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
`ifdef MEM_STREAMER_LAST_EN
  assign bus.out_last  = last_q;
`endif
endmodule
